// File: rtl/viterbi_pkg.sv
// Shared Viterbi decoder parameters and circular column-index helpers.
// The index helpers are used by both the survivor memory and traceback.
package viterbi_pkg;

  localparam int K     = 7;
  localparam int M     = K - 1;
  localparam int D     = 40;
  localparam int NS    = 2 ** M;
  localparam int PTR_W = $clog2(D);
  localparam int CNT_W = $clog2(D + 1);

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [M-1:0]     state_t;
  typedef logic [NS-1:0]    col_t;

  // D need not be a power of two, so wrap explicitly rather than by overflow.
  function automatic ptr_t ptr_inc(input ptr_t p);
    if (p == ptr_t'(D - 1)) return '0;
    return p + ptr_t'(1);
  endfunction

  function automatic ptr_t ptr_dec(input ptr_t p);
    if (p == '0) return ptr_t'(D - 1);
    return p - ptr_t'(1);
  endfunction

endpackage

// File: rtl/survivor_ram.sv
// D x NS simple dual-port survivor store: one write, one registered read,
// read-before-write on address collision.
module survivor_ram
  import viterbi_pkg::*;
(
  input  logic       clk,
  input  logic       we,
  input  ptr_t       waddr,
  input  col_t       wdata,
  input  ptr_t       raddr,
  output col_t       rdata
);

  col_t mem [D];
  col_t rdata_q;

  // NOTE: the array has no reset so it maps onto RAM macros; unwritten
  // columns hold garbage, which traceback never reads before the memory fills.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/survivor_mem.sv
// Circular survivor-decision memory between the ACS array and traceback:
// write pointer, column counter, best end state and a one-cycle bit read port.
module survivor_mem
  import viterbi_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             surv_valid,
  input  logic [NS-1:0]    surv_vec,
  input  logic [M-1:0]     surv_best,
  output logic [PTR_W-1:0] wr_ptr,
  output logic [M-1:0]     s_end,
  output logic             mem_full,
  input  logic [PTR_W-1:0] tb_time,
  input  logic [M-1:0]     tb_state,
  output logic             tb_surv_bit
);

  ptr_t             wr_ptr_q,   wr_ptr_d;
  state_t           s_end_q,    s_end_d;
  logic [CNT_W-1:0] col_cnt_q,  col_cnt_d;
  state_t           rd_state_q, rd_state_d;
  logic             rd_ok_q,    rd_ok_d;
  col_t             rd_col;

  // NOTE: every output of this block gets a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    s_end_d    = s_end_q;
    col_cnt_d  = col_cnt_q;
    rd_state_d = tb_state;
    rd_ok_d    = (tb_time < ptr_t'(D));
    if (surv_valid) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
      s_end_d  = surv_best;
      if (col_cnt_q != CNT_W'(D)) col_cnt_d = col_cnt_q + CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      s_end_q    <= '0;
      col_cnt_q  <= '0;
      rd_state_q <= '0;
      rd_ok_q    <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      s_end_q    <= s_end_d;
      col_cnt_q  <= col_cnt_d;
      rd_state_q <= rd_state_d;
      rd_ok_q    <= rd_ok_d;
    end
  end

  survivor_ram u_ram (
    .clk   (clk),
    .we    (surv_valid),
    .waddr (wr_ptr_q),
    .wdata (surv_vec),
    .raddr (tb_time),
    .rdata (rd_col)
  );

  // Range flag and bit select are registered alongside the column, so the
  // read stays one cycle and an async reset forces the output low at once.
  assign tb_surv_bit = rd_ok_q & rd_col[rd_state_q];
  assign wr_ptr      = wr_ptr_q;
  assign s_end       = s_end_q;
  assign mem_full    = (col_cnt_q == CNT_W'(D));

endmodule

// File: tb/tb_survivor_mem.sv
// Directed self-checking bench for survivor_mem.
module tb_survivor_mem;

  logic        clk;
  logic        rst;
  logic        surv_valid;
  logic [63:0] surv_vec;
  logic [5:0]  surv_best;
  logic [5:0]  wr_ptr;
  logic [5:0]  s_end;
  logic        mem_full;
  logic [5:0]  tb_time;
  logic [5:0]  tb_state;
  logic        tb_surv_bit;

  int n_checks = 0;
  int n_errors = 0;

  survivor_mem dut (
    .clk         (clk),
    .rst         (rst),
    .surv_valid  (surv_valid),
    .surv_vec    (surv_vec),
    .surv_best   (surv_best),
    .wr_ptr      (wr_ptr),
    .s_end       (s_end),
    .mem_full    (mem_full),
    .tb_time     (tb_time),
    .tb_state    (tb_state),
    .tb_surv_bit (tb_surv_bit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_col(input logic [63:0] vec, input logic [5:0] best);
    surv_valid = 1'b1;
    surv_vec   = vec;
    surv_best  = best;
    tick();
    surv_valid = 1'b0;
  endtask

  task automatic read_chk(input string tag, input int t, input int s, input logic exp);
    tb_time  = 6'(t);
    tb_state = 6'(s);
    tick();
    check(tag, 64'(tb_surv_bit), 64'(exp));
  endtask

  function automatic logic [63:0] fill_col(input int i);
    logic [63:0] one = 64'h1;
    if (i == 5) return '1;
    return one << i;
  endfunction

  initial begin
    rst = 1'b1; surv_valid = 1'b0; surv_vec = '0; surv_best = '0;
    tb_time = '0; tb_state = '0;
    #12;
    check("rst_wr_ptr",   64'(wr_ptr), 64'd0);
    check("rst_s_end",    64'(s_end), 64'd0);
    check("rst_mem_full", 64'(mem_full), 64'd0);
    check("rst_tb_bit",   64'(tb_surv_bit), 64'd0);
    rst = 1'b0;
    tick();

    // Three columns, then single-bit reads
    write_col(64'h1, 6'd5);
    write_col(64'h2, 6'd9);
    write_col(64'h8000_0000_0000_0000, 6'd63);
    check("c3_wr_ptr",   64'(wr_ptr), 64'd3);
    check("c3_s_end",    64'(s_end), 64'd63);
    check("c3_mem_full", 64'(mem_full), 64'd0);
    read_chk("rd_0_0",  0, 0, 1'b1);
    read_chk("rd_1_1",  1, 1, 1'b1);
    read_chk("rd_2_63", 2, 63, 1'b1);
    read_chk("rd_2_62", 2, 62, 1'b0);

    // Fill up to D columns
    for (int i = 3; i < 39; i++) write_col(fill_col(i), 6'(i));
    check("c39_wr_ptr",   64'(wr_ptr), 64'd39);
    check("c39_mem_full", 64'(mem_full), 64'd0);
    write_col(fill_col(39), 6'd39);
    check("c40_wr_ptr",   64'(wr_ptr), 64'd0);
    check("c40_mem_full", 64'(mem_full), 64'd1);
    read_chk("rd_39_39", 39, 39, 1'b1);
    read_chk("rd_39_38", 39, 38, 1'b0);

    // Overwrite column 0
    write_col(64'hF0, 6'd11);
    check("c41_wr_ptr",   64'(wr_ptr), 64'd1);
    check("c41_mem_full", 64'(mem_full), 64'd1);
    read_chk("rd_0_4_new", 0, 4, 1'b1);
    read_chk("rd_0_0_new", 0, 0, 1'b0);

    // Advance to wr_ptr=5, then collide with column 5 (all ones)
    for (int i = 1; i < 5; i++) write_col(fill_col(i), 6'(i));
    check("pre_col_wr_ptr", 64'(wr_ptr), 64'd5);
    tb_time  = 6'd5;
    tb_state = 6'd17;
    write_col(64'h0, 6'd42);
    check("collide_old", 64'(tb_surv_bit), 64'd1);
    tick();
    check("collide_new", 64'(tb_surv_bit), 64'd0);

    // surv_valid low: nothing in the write path moves
    for (int i = 0; i < 10; i++) begin
      surv_vec  = {$urandom, $urandom};
      surv_best = 6'($urandom_range(0, 63));
      tick();
    end
    check("idle_wr_ptr",   64'(wr_ptr), 64'd6);
    check("idle_s_end",    64'(s_end), 64'd42);
    check("idle_mem_full", 64'(mem_full), 64'd1);
    read_chk("idle_rd_6_6", 6, 6, 1'b1);
    read_chk("idle_rd_6_7", 6, 7, 1'b0);
    read_chk("idle_rd_5_0", 5, 0, 1'b0);

    // Out-of-range read addresses
    read_chk("pre_oor_rd", 7, 7, 1'b1);
    read_chk("oor_40_0",  40, 0, 1'b0);
    read_chk("pre_oor_rd2", 5 + 1, 6, 1'b1);
    read_chk("oor_40_63", 40, 63, 1'b0);
    read_chk("oor_63_6",  63, 6, 1'b0);

    // Async reset mid-stream after 20 writes
    rst = 1'b1; #2; rst = 1'b0;
    tick();
    for (int i = 0; i < 20; i++) write_col('1, 6'd7);
    read_chk("pre_rst_rd", 3, 10, 1'b1);
    check("pre_rst_wr_ptr", 64'(wr_ptr), 64'd20);
    check("pre_rst_s_end",  64'(s_end), 64'd7);
    #3;
    rst = 1'b1;
    #1;
    check("arst_wr_ptr",   64'(wr_ptr), 64'd0);
    check("arst_s_end",    64'(s_end), 64'd0);
    check("arst_mem_full", 64'(mem_full), 64'd0);
    check("arst_tb_bit",   64'(tb_surv_bit), 64'd0);
    #1;
    rst = 1'b0;
    tick();
    for (int i = 0; i < 39; i++) write_col(fill_col(i), 6'd1);
    check("refill39_full",   64'(mem_full), 64'd0);
    check("refill39_wr_ptr", 64'(wr_ptr), 64'd39);
    write_col(64'h0, 6'd2);
    check("refill40_full",   64'(mem_full), 64'd1);
    check("refill40_wr_ptr", 64'(wr_ptr), 64'd0);
    check("refill40_s_end",  64'(s_end), 64'd2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
